// File: rtl/ws2812b_frame_scheduler_if.sv
// Host write port, frame request/status and serializer pixel stream of the
// WS2812B frame scheduler, bundled so host and scheduler agree on one signal set.
interface ws2812b_frame_scheduler_if;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        latch;

  modport master (
    output wr_en, wr_addr, wr_data, start, px_ready,
    input  busy, frame_done, px_data, px_valid, latch
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, px_ready,
    output busy, frame_done, px_data, px_valid, latch
  );
endinterface

// File: rtl/ws2812b_frame_scheduler.sv
// Double-buffered WS2812B frame controller: snapshots the host pixel store,
// streams one GRB word per LED to the serializer, then holds the latch gap.
module ws2812b_frame_scheduler #(
  parameter int NUM_LEDS       = 4,
  parameter int RESET_CYCLES   = 2500,
  parameter int REFRESH_CYCLES = 0
) (
  input logic                      clock,
  input logic                      reset,
  ws2812b_frame_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  localparam logic [7:0]  LAST_IDX     = 8'(NUM_LEDS - 1);
  localparam logic [15:0] LATCH_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [23:0] REFRESH_LAST = 24'(REFRESH_CYCLES - 1);
  localparam bit          REFRESH_EN   = (REFRESH_CYCLES > 0);

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] latchCnt_q, latchCnt_d;
  logic [23:0] refreshCnt_q, refreshCnt_d;
  logic        pending_q, pending_d;
  logic [23:0] pxData_q, pxData_d;
  logic        frameDone_q, frameDone_d;

  logic [23:0] back_q  [NUM_LEDS];
  logic [23:0] back_d  [NUM_LEDS];
  logic [23:0] front_q [NUM_LEDS];

  logic        snapshot;
  logic [7:0]  nextIdx;
  logic [23:0] frontNext;
  logic        refreshHit;
  logic        requestNow;

  // Host writes land in back_d first so a snapshot taken in the same cycle sees them.
  always_comb begin
    back_d = back_q;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bus.wr_en && (bus.wr_addr == 8'(i))) begin
        back_d[i] = bus.wr_data;
      end
    end
  end

  always_comb begin
    nextIdx   = idx_q + 8'd1;
    frontNext = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (nextIdx == 8'(i)) begin
        frontNext = front_q[i];
      end
    end
  end

  assign refreshHit = REFRESH_EN && (refreshCnt_q == REFRESH_LAST);
  assign requestNow = pending_q | bus.start;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    latchCnt_d   = latchCnt_q;
    refreshCnt_d = refreshCnt_q;
    pending_d    = pending_q;
    pxData_d     = pxData_q;
    frameDone_d  = 1'b0;
    snapshot     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start || refreshHit) begin
          snapshot     = 1'b1;
          state_d      = SEND;
          idx_d        = '0;
          refreshCnt_d = '0;
          pxData_d     = back_d[0];
        end else if (REFRESH_EN) begin
          refreshCnt_d = refreshCnt_q + 24'd1;
        end
      end

      SEND: begin
        pending_d = requestNow;
        if (bus.px_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d    = LATCH;
            latchCnt_d = '0;
          end else begin
            idx_d    = nextIdx;
            pxData_d = frontNext;
          end
        end
      end

      LATCH: begin
        if (latchCnt_q == LATCH_LAST) begin
          frameDone_d = 1'b1;
          // A request seen during the frame chains straight into a fresh one.
          if (requestNow) begin
            pending_d    = 1'b0;
            snapshot     = 1'b1;
            state_d      = SEND;
            idx_d        = '0;
            refreshCnt_d = '0;
            pxData_d     = back_d[0];
          end else begin
            state_d = IDLE;
          end
        end else begin
          latchCnt_d = latchCnt_q + 16'd1;
          pending_d  = requestNow;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      latchCnt_q   <= '0;
      refreshCnt_q <= '0;
      pending_q    <= 1'b0;
      pxData_q     <= '0;
      frameDone_q  <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      latchCnt_q   <= latchCnt_d;
      refreshCnt_q <= refreshCnt_d;
      pending_q    <= pending_d;
      pxData_q     <= pxData_d;
      frameDone_q  <= frameDone_d;
      back_q       <= back_d;
      if (snapshot) begin
        front_q <= back_d;
      end
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.px_valid   = (state_q == SEND);
  assign bus.latch      = (state_q == LATCH);
  assign bus.px_data    = pxData_q;
  assign bus.frame_done = frameDone_q;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for the WS2812B frame scheduler: unit A drives the manual-start
// frames, unit B runs with auto-refresh and a short latch gap.
module tb_ws2812b_frame_scheduler;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ws2812b_frame_scheduler_if busA ();
  ws2812b_frame_scheduler_if busB ();

  ws2812b_frame_scheduler #(
    .NUM_LEDS(4), .RESET_CYCLES(2500), .REFRESH_CYCLES(0)
  ) dutA (
    .clock(clock), .reset(reset), .bus(busA)
  );

  ws2812b_frame_scheduler #(
    .NUM_LEDS(4), .RESET_CYCLES(10), .REFRESH_CYCLES(100)
  ) dutB (
    .clock(clock), .reset(reset), .bus(busB)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives unit A's inputs for one clock edge, then samples just after it.
  task automatic applyStimulus(input logic wrEn, input logic [7:0] addr,
                               input logic [23:0] data, input logic go,
                               input logic ready);
    busA.wr_en    = wrEn;
    busA.wr_addr  = addr;
    busA.wr_data  = data;
    busA.start    = go;
    busA.px_ready = ready;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Starts at the cycle presenting pixel 0 and ends on the first latch cycle.
  task automatic streamFrame(input string tag, input logic [23:0] p0,
                             input logic [23:0] p1, input logic [23:0] p2,
                             input logic [23:0] p3);
    logic [23:0] expPx [4];
    expPx = '{p0, p1, p2, p3};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("%s.valid%0d", tag, k), 32'(busA.px_valid), 32'd1);
      checkOutput($sformatf("%s.data%0d", tag, k), 32'(busA.px_data), 32'(expPx[k]));
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    end
    checkOutput({tag, ".latchOn"}, 32'(busA.latch), 32'd1);
    checkOutput({tag, ".validOff"}, 32'(busA.px_valid), 32'd0);
  endtask

  task automatic waitLatchEnd(input string tag, input int expLen);
    int n     = 0;
    int drops = 0;
    while (busA.latch === 1'b1 && n < expLen + 16) begin
      if (busA.busy !== 1'b1) drops++;
      n++;
      tick();
    end
    checkOutput({tag, ".latchLen"}, 32'(n), 32'(expLen));
    checkOutput({tag, ".busyHeld"}, 32'(drops), 32'd0);
    checkOutput({tag, ".frameDone"}, 32'(busA.frame_done), 32'd1);
  endtask

  initial begin
    int n;
    int m;
    int aAct;

    busA.wr_en = 1'b0; busA.wr_addr = '0; busA.wr_data = '0;
    busA.start = 1'b0; busA.px_ready = 1'b0;
    busB.wr_en = 1'b0; busB.wr_addr = '0; busB.wr_data = '0;
    busB.start = 1'b0; busB.px_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst.busy", 32'(busA.busy), 32'd0);
    checkOutput("rst.frameDone", 32'(busA.frame_done), 32'd0);
    checkOutput("rst.pxValid", 32'(busA.px_valid), 32'd0);
    checkOutput("rst.pxData", 32'(busA.px_data), 32'd0);
    checkOutput("rst.latch", 32'(busA.latch), 32'd0);
    checkOutput("rst.busyB", 32'(busB.busy), 32'd0);
    reset = 1'b0;

    // Basic frame
    applyStimulus(1'b1, 8'd0, 24'h00FF00, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd1, 24'hFF0000, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd2, 24'h0000FF, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'd3, 24'h123456, 1'b0, 1'b1);
    checkOutput("basic.idleBusy", 32'(busA.busy), 32'd0);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    checkOutput("basic.busy", 32'(busA.busy), 32'd1);
    streamFrame("basic", 24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h123456);
    waitLatchEnd("basic", 2500);
    checkOutput("basic.busyDone", 32'(busA.busy), 32'd0);
    checkOutput("basic.latchOff", 32'(busA.latch), 32'd0);
    tick();
    checkOutput("basic.donePulse", 32'(busA.frame_done), 32'd0);

    // Backpressure on pixel 2, host write of LED 1 mid-frame
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    checkOutput("bp.data0", 32'(busA.px_data), 32'h00FF00);
    applyStimulus(1'b1, 8'd1, 24'hAAAAAA, 1'b0, 1'b1);
    checkOutput("bp.oldData1", 32'(busA.px_data), 32'hFF0000);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0);
      checkOutput($sformatf("bp.hold%0d", k), {busA.px_valid, 7'd0, busA.px_data},
                  {1'b1, 7'd0, 24'h0000FF});
    end
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    checkOutput("bp.data3", 32'(busA.px_data), 32'h123456);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    checkOutput("bp.latchOn", 32'(busA.latch), 32'd1);
    waitLatchEnd("bp", 2500);

    // Next frame carries the new LED 1; three starts during its latch gap
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    streamFrame("snap", 24'h00FF00, 24'hAAAAAA, 24'h0000FF, 24'h123456);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    waitLatchEnd("pend", 2494);
    checkOutput("pend.busyKept", 32'(busA.busy), 32'd1);
    checkOutput("pend.latchOff", 32'(busA.latch), 32'd0);
    streamFrame("pendFrame", 24'h00FF00, 24'hAAAAAA, 24'h0000FF, 24'h123456);
    waitLatchEnd("pendFrame", 2500);
    checkOutput("pendFrame.busyDone", 32'(busA.busy), 32'd0);
    tick();
    checkOutput("pend.noThird", {30'd0, busA.busy, busA.px_valid}, 32'd0);

    // Out-of-range write is dropped; same-cycle write and start is write-first
    applyStimulus(1'b1, 8'd4, 24'hDEADBE, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    streamFrame("addr4", 24'h00FF00, 24'hAAAAAA, 24'h0000FF, 24'h123456);
    waitLatchEnd("addr4", 2500);
    applyStimulus(1'b1, 8'd0, 24'h112233, 1'b1, 1'b1);
    checkOutput("wfirst.data0", 32'(busA.px_data), 32'h112233);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    checkOutput("wfirst.data1", 32'(busA.px_data), 32'hAAAAAA);
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    checkOutput("wfirst.data2", 32'(busA.px_data), 32'h0000FF);

    // Reset while pixel 2 is on the bus
    reset = 1'b1;
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1);
    reset = 1'b0;
    checkOutput("midRst.busy", 32'(busA.busy), 32'd0);
    checkOutput("midRst.pxValid", 32'(busA.px_valid), 32'd0);
    checkOutput("midRst.pxData", 32'(busA.px_data), 32'd0);
    checkOutput("midRst.latch", 32'(busA.latch), 32'd0);
    checkOutput("midRst.frameDone", 32'(busA.frame_done), 32'd0);

    // Auto-refresh on unit B, counted from its reset; unit A must stay idle
    n    = 0;
    aAct = 0;
    while (busB.busy !== 1'b1 && n < 300) begin
      if (busA.busy !== 1'b0 || busA.frame_done !== 1'b0) aAct++;
      tick();
      n++;
    end
    checkOutput("refresh.firstGap", 32'(n), 32'd100);
    checkOutput("midRst.noActivity", 32'(aAct), 32'd0);
    checkOutput("refresh.pxValid", 32'(busB.px_valid), 32'd1);
    m = 0;
    while (busB.frame_done !== 1'b1 && m < 100) begin
      tick();
      m++;
    end
    checkOutput("refresh.frameLen", 32'(m), 32'd14);
    n = 0;
    while (busB.busy !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("refresh.secondGap", 32'(n), 32'd100);

    // Buffers of unit A were cleared by the reset
    applyStimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b1);
    streamFrame("cleared", 24'h000000, 24'h000000, 24'h000000, 24'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
